fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Fetch-stage controller upstream of decode; owns the next-PC path.
- Reads the current PC from the 32-bit PC register and drives that register's load enable and data.
- Issues single-outstanding instruction-memory requests and buffers returned words, tagged with their PC, in a small FIFO for decode.
- Handles branch/exception redirects by reloading the PC and discarding in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded while reset is high.
- DEPTH, 2, fetch-buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high reset.
- pc_q  in  32  current PC, taken from the PC register output.
- pc_ld  out  1  load enable to the PC register.
- pc_d  out  32  next PC value to the PC register.
- mem_req  out  1  instruction fetch request.
- mem_addr  out  32  fetch address; equals pc_q while mem_req=1.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  instruction word.
- redirect  in  1  change of flow this cycle.
- redirect_pc  in  32  target PC.
- dec_valid  out  1  buffer head valid toward decode.
- dec_ready  in  1  decode accepts the head.
- dec_instr  out  32  head instruction word.
- dec_pc  out  32  PC of the head instruction.

Behaviour:
- Reset:
  - While reset=1: pc_ld=1, pc_d=RESET_PC, mem_req=0, dec_valid=0, FIFO count=0, state=FETCH.
  - Reset mid-transaction abandons any outstanding response. Memory must not return rvalid for a pre-reset request after reset deasserts.
- FSM states: FETCH, WAIT, DRAIN.
- Credit: req_ok = (count + (state!=FETCH)) < DEPTH. The FIFO can never overflow.
- FETCH:
  - mem_req = req_ok & ~redirect; mem_addr = pc_q.
  - On mem_req & mem_gnt: pc_ld=1, pc_d=pc_q+4 (wraps mod 2^32), latch req_pc=pc_q, go to WAIT.
  - Without gnt, hold mem_req and mem_addr stable.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: push {req_pc, mem_rdata}, go to FETCH. The next request is issued no earlier than the following cycle, so a back-to-back fetch takes at least 2 cycles.
- DRAIN:
  - mem_req=0.
  - On mem_rvalid: discard the data, go to FETCH.
- Redirect (highest priority, any state):
  - pc_ld=1, pc_d = {redirect_pc[31:2], 2'b00}.
  - FIFO flushed: count=0 and dec_valid=0 from the next cycle. A same-cycle pop is ignored and a same-cycle push is dropped.
  - FETCH stays in FETCH (mem_req is forced 0, so no grant is possible that cycle).
  - WAIT without rvalid goes to DRAIN. WAIT with rvalid discards the data and goes to FETCH.
  - DRAIN stays in DRAIN, or goes to FETCH if rvalid arrives that cycle.
- pc_ld=0 in every other cycle, so the PC register holds its value.
- FIFO:
  - dec_valid = (count!=0); dec_instr and dec_pc come from the head entry.
  - Pop on dec_valid & dec_ready.
  - Simultaneous push and pop keeps count unchanged; push and pop both apply, including when full.
  - Pointers wrap mod DEPTH.
  - Head entry is stable while dec_valid=1 and dec_ready=0.
- Latency without the optional feature: mem_rvalid in cycle N gives dec_valid=1 in cycle N+1.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty, state=WAIT, mem_rvalid=1 and redirect=0, then dec_valid=1 combinationally in the same cycle, with dec_instr=mem_rdata and dec_pc=req_pc.
  - If dec_ready=1 that cycle, the word is consumed and not pushed. Otherwise it is pushed normally.
- Undefined: no combinational path from mem_rvalid or mem_rdata to the dec_* outputs; 1-cycle latency as stated above.

Test Plan:
- Reset with RESET_PC=32'h100, hold reset for 2 cycles -> pc_ld=1, pc_d=32'h100 each reset cycle; mem_req=0 and dec_valid=0; first mem_addr=32'h100 the cycle after reset drops.
- Zero-wait memory (gnt immediate, rvalid the next cycle), dec_ready=1 -> decode receives (PC 100, 104, 108) with instructions matching memory; pc_ld pulses only on grant cycles.
- dec_ready=0 with DEPTH=2 -> exactly 2 words buffered, then mem_req stays 0. Raise dec_ready -> entries drain in order and fetching resumes at 32'h108.
- Redirect to 32'h203 while in WAIT, with rvalid 3 cycles later -> pc_d=32'h200; FIFO empty next cycle; the late response is discarded; next mem_addr=32'h200.
- Redirect in the same cycle as rvalid and a pop with a full FIFO -> count=0 next cycle, no stale word reaches decode, state=FETCH.
- With FETCH_BYPASS_EN: empty FIFO, dec_ready=1, rvalid with rdata=32'hE3A00001 -> dec_valid=1 in that cycle with matching dec_instr, and the FIFO stays empty.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: drives the external PC register, issues one outstanding
// instruction fetch at a time and buffers tagged words for decode. Optional FETCH_BYPASS_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_q,
  output logic        pc_ld,
  output logic [31:0] pc_d,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshakes: a memory request transfers when mem_req & mem_gnt; a decode word
  // transfers when dec_valid & dec_ready. Valid never waits on ready.
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     buf_instr [DEPTH];
  logic [31:0]     buf_pc    [DEPTH];
  logic [31:0]     req_pc;
  logic            req_ok, grant, push, pop, flush, fifo_valid, bypass_take;

  // One credit is reserved for the response of an outstanding or draining fetch.
  assign req_ok     = (count + CW'(state != FETCH)) < CW'(DEPTH);
  assign fifo_valid = (count != '0);
  assign mem_addr   = pc_q;
  assign pop        = fifo_valid & dec_ready & ~redirect & ~reset;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = ~reset & ~redirect & (state == WAIT) & mem_rvalid & ~fifo_valid;
  assign bypass_take = bypass_hit & dec_ready;
  assign dec_valid   = ~reset & (fifo_valid | bypass_hit);
  assign dec_instr   = fifo_valid ? buf_instr[rd_ptr] : mem_rdata;
  assign dec_pc      = fifo_valid ? buf_pc[rd_ptr]    : req_pc;
`else
  assign bypass_take = 1'b0;
  assign dec_valid   = ~reset & fifo_valid;
  assign dec_instr   = buf_instr[rd_ptr];
  assign dec_pc      = buf_pc[rd_ptr];
`endif

  always_comb begin
    state_nx = state;
    pc_ld    = 1'b0;
    pc_d     = pc_q;
    mem_req  = 1'b0;
    grant    = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    if (reset) begin
      pc_ld    = 1'b1;
      pc_d     = RESET_PC;
      state_nx = FETCH;
    end else if (redirect) begin
      pc_ld = 1'b1;
      pc_d  = redirect_pc & 32'hFFFF_FFFC;
      flush = 1'b1;
      case (state)
        FETCH:       state_nx = FETCH;
        WAIT, DRAIN: state_nx = mem_rvalid ? FETCH : DRAIN;
        default:     state_nx = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          mem_req = req_ok;
          if (req_ok && mem_gnt) begin
            grant    = 1'b1;
            pc_ld    = 1'b1;
            pc_d     = pc_q + 32'd4;
            state_nx = WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            push     = ~bypass_take;
            state_nx = FETCH;
          end
        end
        DRAIN: begin
          if (mem_rvalid) state_nx = FETCH;
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Data storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= mem_rdata;
      buf_pc[wr_ptr]    <= req_pc;
    end
    if (grant) req_pc <= pc_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: external PC register and a simple memory
// model around the DUT, one task per scenario. Honours FETCH_BYPASS_EN.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_reg;
  logic        pc_ld;
  logic [31:0] pc_d;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  logic        auto_en, man_gnt, man_rvalid;
  logic [31:0] man_rdata;
  logic        auto_rvalid;
  logic [31:0] auto_rdata;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  fetch_sequencer #(.RESET_PC(32'h100), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc_q(pc_reg), .pc_ld(pc_ld), .pc_d(pc_d),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  // Clock / PC register / memory model
  always #5 clk = ~clk;

  always @(posedge clk) if (pc_ld) pc_reg <= pc_d;

  always @(posedge clk) begin
    auto_rvalid <= auto_en && mem_req && mem_gnt;
    auto_rdata  <= 32'hE000_0000 | mem_addr;
  end

  assign mem_gnt    = auto_en ? mem_req     : man_gnt;
  assign mem_rvalid = auto_en ? auto_rvalid : man_rvalid;
  assign mem_rdata  = auto_en ? auto_rdata  : man_rdata;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the first post-reset edge (cycle C0).
  task automatic do_reset();
    reset = 1'b1; auto_en = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;
    man_rdata = '0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; auto_en = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;
    man_rdata = '0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (pc_ld !== 1'b1) begin failures++; $display("FAIL reset_pc_ld cyc%0d got=%b exp=1", i, pc_ld); end
      checks++; if (pc_d !== 32'h100) begin failures++; $display("FAIL reset_pc_d cyc%0d got=%h exp=00000100", i, pc_d); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req cyc%0d got=%b exp=0", i, mem_req); end
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid cyc%0d got=%b exp=0", i, dec_valid); end
      @(posedge clk);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL reset_first_addr got=%h exp=00000100", mem_addr); end
    checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.state); end
  endtask

  task automatic test_stream();
    int cyc;
    logic [63:0] e;
    do_reset();
    exp_q = {};
    exp_q.push_back({32'h100, 32'hE000_0100});
    exp_q.push_back({32'h104, 32'hE000_0104});
    exp_q.push_back({32'h108, 32'hE000_0108});
    auto_en = 1'b1; dec_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      @(negedge clk);
      checks++; if (pc_ld !== (mem_req & mem_gnt)) begin failures++; $display("FAIL stream_pc_ld cyc%0d got=%b exp=%b", cyc, pc_ld, mem_req & mem_gnt); end
      if (dec_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++; if ({dec_pc, dec_instr} !== e) begin failures++; $display("FAIL stream_word got=%h/%h exp=%h/%h", dec_pc, dec_instr, e[63:32], e[31:0]); end
      end
      cyc++;
      next_cycle();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_timeout got=%0d exp=0 words left", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int grants, cyc;
    logic seen_req;
    logic [63:0] e;
    do_reset();
    auto_en = 1'b1; dec_ready = 1'b0;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req && mem_gnt) grants++;
      next_cycle();
    end
    @(negedge clk);
    checks++; if (grants != 2) begin failures++; $display("FAIL bp_grants got=%0d exp=2", grants); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL bp_req_stalled got=%b exp=0", mem_req); end
    checks++; if (dut.count !== 2'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", dut.count); end
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/00000100", dec_valid, dec_pc); end
    next_cycle();
    dec_ready = 1'b1;
    exp_q = {};
    exp_q.push_back({32'h100, 32'hE000_0100});
    exp_q.push_back({32'h104, 32'hE000_0104});
    seen_req = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || !seen_req) && cyc < 10) begin
      @(negedge clk);
      if (dec_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if ({dec_pc, dec_instr} !== e) begin failures++; $display("FAIL bp_drain got=%h/%h exp=%h/%h", dec_pc, dec_instr, e[63:32], e[31:0]); end
      end
      if (mem_req === 1'b1 && !seen_req) begin
        seen_req = 1'b1;
        checks++; if (mem_addr !== 32'h108) begin failures++; $display("FAIL bp_resume_addr got=%h exp=00000108", mem_addr); end
      end
      cyc++;
      next_cycle();
    end
    checks++; if (exp_q.size() != 0 || !seen_req) begin failures++; $display("FAIL bp_timeout got=%0d/%b exp=0/1", exp_q.size(), seen_req); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    man_gnt = 1'b1;                                    // C0: grant 0x100
    @(negedge clk);
    checks++; if (pc_ld !== 1'b1 || pc_d !== 32'h104) begin failures++; $display("FAIL rw_grant_pc got=%b/%h exp=1/00000104", pc_ld, pc_d); end
    next_cycle();
    man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hE000_0100;   // C1
    @(negedge clk);
`ifndef FETCH_BYPASS_EN
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rw_latency_n got=%b exp=0", dec_valid); end
`endif
    next_cycle();
    man_rvalid = 1'b0; man_gnt = 1'b1;               // C2: word visible, grant 0x104
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== 32'hE000_0100) begin failures++; $display("FAIL rw_latency_n1 got=%b/%h/%h exp=1/00000100/e0000100", dec_valid, dec_pc, dec_instr); end
    checks++; if (mem_addr !== 32'h104) begin failures++; $display("FAIL rw_addr2 got=%h exp=00000104", mem_addr); end
    next_cycle();
    man_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h203;   // C3: redirect in WAIT
    @(negedge clk);
    checks++; if (pc_ld !== 1'b1 || pc_d !== 32'h200) begin failures++; $display("FAIL rw_redirect_pc got=%b/%h exp=1/00000200", pc_ld, pc_d); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rw_redirect_req got=%b exp=0", mem_req); end
    next_cycle();
    redirect = 1'b0;                                   // C4
    @(negedge clk);
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rw_flushed got=%b exp=0", dec_valid); end
    checks++; if (dut.state !== 2'd2) begin failures++; $display("FAIL rw_drain_state got=%0d exp=2", dut.state); end
    next_cycle();                                      // C5
    next_cycle();
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;     // C6: late response
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("FAIL rw_late_rsp got=%b/%b exp=0/0", mem_req, dec_valid); end
    next_cycle();
    man_rvalid = 1'b0;                                 // C7
    @(negedge clk);
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rw_discard got=%b exp=0", dec_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin failures++; $display("FAIL rw_new_addr got=%b/%h exp=1/00000200", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_full();
    do_reset();
    auto_en = 1'b1; dec_ready = 1'b0;
    repeat (5) next_cycle();
    auto_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h300; dec_ready = 1'b1;
    @(negedge clk);
    checks++; if (dut.count !== 2'd2 || dec_valid !== 1'b1) begin failures++; $display("FAIL rf_full_pre got=%0d/%b exp=2/1", dut.count, dec_valid); end
    checks++; if (pc_ld !== 1'b1 || pc_d !== 32'h300) begin failures++; $display("FAIL rf_redirect_pc got=%b/%h exp=1/00000300", pc_ld, pc_d); end
    next_cycle();
    redirect = 1'b0; man_gnt = 1'b1;
    @(negedge clk);
    checks++; if (dut.count !== 2'd0 || dec_valid !== 1'b0) begin failures++; $display("FAIL rf_flush_full got=%0d/%b exp=0/0", dut.count, dec_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin failures++; $display("FAIL rf_addr300 got=%b/%h exp=1/00000300", mem_req, mem_addr); end
    next_cycle();
    man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hE000_0300; dec_ready = 1'b0;
    next_cycle();
    man_rvalid = 1'b0; man_gnt = 1'b1;                 // grant 0x304 with one word buffered
    next_cycle();
    man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hE000_0304;
    redirect = 1'b1; redirect_pc = 32'h400; dec_ready = 1'b1;
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h300) begin failures++; $display("FAIL rf_head_pre got=%b/%h exp=1/00000300", dec_valid, dec_pc); end
    checks++; if (pc_d !== 32'h400) begin failures++; $display("FAIL rf_redirect2_pc got=%h exp=00000400", pc_d); end
    next_cycle();
    redirect = 1'b0; man_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (dut.count !== 2'd0 || dec_valid !== 1'b0) begin failures++; $display("FAIL rf_flush_wait got=%0d/%b exp=0/0", dut.count, dec_valid); end
    checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL rf_state got=%0d exp=0", dut.state); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin failures++; $display("FAIL rf_addr400 got=%b/%h exp=1/00000400", mem_req, mem_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rf_no_stale got=%b exp=0", dec_valid); end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    dec_ready = 1'b1; man_gnt = 1'b1;
    next_cycle();
    man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hE3A0_0001;
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'hE3A0_0001 || dec_pc !== 32'h100) begin failures++; $display("FAIL bypass_word got=%b/%h/%h exp=1/e3a00001/00000100", dec_valid, dec_instr, dec_pc); end
    next_cycle();
    man_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (dut.count !== 2'd0 || dec_valid !== 1'b0) begin failures++; $display("FAIL bypass_empty got=%0d/%b exp=0/0", dut.count, dec_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_full();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
